// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter: sequences I/D-cache refill and victim write-back onto one memory port
// and raises the pipeline stall while a miss is outstanding.
module mem_refill_arbiter #(
    parameter int addr_size  = 32,
    parameter int line_words = 4,
    parameter int idx_w      = $clog2(line_words)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ic_miss,
    input  logic [addr_size-1:0] ic_addr,
    input  logic                 dc_miss,
    input  logic [addr_size-1:0] dc_addr,
    input  logic                 dc_dirty,
    input  logic [addr_size-1:0] dc_victim_addr,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [addr_size-1:0] mem_addr,
    output logic [idx_w-1:0]     word_idx,
    output logic                 ic_fill,
    output logic                 dc_fill,
    output logic                 dc_wb_rd,
    output logic                 stall
);
    typedef enum logic [2:0] {IDLE, DC_WB, DC_FILL, IC_FILL, DONE} state_t;

    localparam logic [addr_size-1:0] line_mask = ~addr_size'(4 * line_words - 1);

    state_t                 state_q, state_d;
    logic [idx_w-1:0]       word_idx_q, word_idx_d;
    logic [addr_size-1:0]   base_q, base_d, victim_q, victim_d;
    logic                   mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic                   last;

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        base_d     = base_q;
        victim_d   = victim_q;
        last       = word_idx_q == idx_w'(line_words - 1);
        case (state_q)
            IDLE: begin
                if (dc_miss || ic_miss) begin
                    state_d  = dc_miss ? (dc_dirty ? DC_WB : DC_FILL) : IC_FILL;
                    base_d   = (dc_miss ? dc_addr : ic_addr) & line_mask;
                    victim_d = dc_victim_addr & line_mask;
                end
            end
            DONE: state_d = IDLE;
            default: begin
                // the index wraps to 0 on the last word because the line size is a power of two
                if (mem_ready) begin
                    word_idx_d = word_idx_q + idx_w'(1);
                    if (last)
                        state_d = state_q == DC_WB ? DC_FILL : DONE;
                end
            end
        endcase
        mem_req_d = state_d inside {DC_WB, DC_FILL, IC_FILL};
        mem_we_d  = state_d == DC_WB;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            word_idx_q <= '0;
            base_q     <= '0;
            victim_q   <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            base_q     <= base_d;
            victim_q   <= victim_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_we   = mem_we_q;
    assign word_idx = word_idx_q;
    assign mem_addr = (state_q == DC_WB ? victim_q : base_q)
                    + {{(addr_size - idx_w - 2){1'b0}}, word_idx_q, 2'b00};
    assign ic_fill  = (state_q == IC_FILL) && mem_ready;
    assign dc_fill  = (state_q == DC_FILL) && mem_ready;
    assign dc_wb_rd = state_q == DC_WB;
    assign stall    = ic_miss || dc_miss || (state_q != IDLE);
endmodule

// File: tb/tb_mem_refill_arbiter.sv
// tb_mem_refill_arbiter: scoreboard bench; the driver queues the expected word transfers of each
// miss service and a negedge monitor compares every memory-port cycle against the queue head.
module tb_mem_refill_arbiter;
    localparam int AW = 32;
    localparam int LW = 4;
    localparam int IW = 2;
    localparam logic [31:0] MASK = ~32'(4 * LW - 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ic_miss = 1'b0, dc_miss = 1'b0, dc_dirty = 1'b0, mem_ready = 1'b0;
    logic [AW-1:0] ic_addr = '0, dc_addr = '0, dc_victim_addr = '0;
    logic          mem_req, mem_we, ic_fill, dc_fill, dc_wb_rd, stall;
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] word_idx;

    mem_refill_arbiter #(.addr_size(AW), .line_words(LW)) dut (
        .clk(clk), .rst(rst), .ic_miss(ic_miss), .ic_addr(ic_addr), .dc_miss(dc_miss),
        .dc_addr(dc_addr), .dc_dirty(dc_dirty), .dc_victim_addr(dc_victim_addr),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .word_idx(word_idx), .ic_fill(ic_fill), .dc_fill(dc_fill), .dc_wb_rd(dc_wb_rd),
        .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        bit          ic;
        logic [31:0] addr;
        int          idx;
    } xfer_t;

    xfer_t exp_q[$];
    int    n_vec = 0, n_err = 0;
    int    ic_seen = 0, dc_seen = 0, stall_cnt = 0;
    bit    done_pend = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        xfer_t e;
        if (!rst) begin
            if (stall) stall_cnt++;
            chk("stall", 64'(stall), 64'(ic_miss | dc_miss | done_pend));
            if (mem_req) begin
                if (exp_q.size() == 0) chk("spurious_req", 64'(mem_req), 64'd0);
                else begin
                    e = exp_q[0];
                    chk("mem_we", 64'(mem_we), 64'(e.we));
                    chk("mem_addr", 64'(mem_addr), 64'(e.addr));
                    chk("word_idx", 64'(word_idx), 64'(e.idx));
                    chk("dc_wb_rd", 64'(dc_wb_rd), 64'(e.we));
                    chk("ic_fill", 64'(ic_fill), 64'(e.ic && mem_ready));
                    chk("dc_fill", 64'(dc_fill), 64'(!e.ic && !e.we && mem_ready));
                    if (mem_ready) begin
                        void'(exp_q.pop_front());
                        if (e.ic) ic_seen++;
                        else if (!e.we) dc_seen++;
                    end
                end
            end else
                chk("idle_outputs", {60'd0, ic_fill, dc_fill, dc_wb_rd, mem_we}, 64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // period 0 = random mem_ready, otherwise ready once every 'period' cycles
    task automatic serve(input bit ic, input bit dc, input bit dirty, input logic [31:0] ia,
                         input logic [31:0] da, input logic [31:0] va, input int period);
        int cyc = 0;
        int ic0 = ic_seen;
        int dc0 = dc_seen;
        int s0  = stall_cnt;
        int exp_cycles = 0;
        if (dc) begin
            if (dirty)
                for (int i = 0; i < LW; i++)
                    exp_q.push_back('{we: 1'b1, ic: 1'b0, addr: (va & MASK) + 32'(4 * i), idx: i});
            for (int i = 0; i < LW; i++)
                exp_q.push_back('{we: 1'b0, ic: 1'b0, addr: (da & MASK) + 32'(4 * i), idx: i});
            exp_cycles += 2 + LW * (dirty ? 2 : 1);
        end
        if (ic) begin
            for (int i = 0; i < LW; i++)
                exp_q.push_back('{we: 1'b0, ic: 1'b1, addr: (ia & MASK) + 32'(4 * i), idx: i});
            exp_cycles += 2 + LW;
        end
        ic_miss = ic; dc_miss = dc; dc_dirty = dirty;
        ic_addr = ia; dc_addr = da; dc_victim_addr = va;
        while ((ic_miss || dc_miss || done_pend) && cyc < 300) begin
            mem_ready = period == 0 ? 1'($urandom_range(0, 1)) : (cyc % period == period - 1);
            step();
            cyc++;
            done_pend = 1'b0;
            if (dc_miss && dc_seen - dc0 == LW) begin dc_miss = 1'b0; done_pend = 1'b1; end
            if (ic_miss && ic_seen - ic0 == LW) begin ic_miss = 1'b0; done_pend = 1'b1; end
        end
        if (cyc >= 300) begin
            n_vec++; n_err++;
            $display("FAIL service_timeout: got %0d fills expected %0d", exp_q.size(), 0);
            exp_q.delete(); ic_miss = 1'b0; dc_miss = 1'b0; done_pend = 1'b0;
        end
        if (period == 1) chk("service_cycles", 64'(stall_cnt - s0), 64'(exp_cycles));
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        mem_ready = 1'($urandom_range(0, 1));
        step();
    endtask

    initial begin
        int ic0;
        int cyc;
        rst = 1'b1;
        mem_ready = 1'b1;
        step();
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_word_idx", 64'(word_idx), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_fills", {61'd0, ic_fill, dc_fill, dc_wb_rd}, 64'd0);
        chk("rst_stall_low", 64'(stall), 64'd0);
        dc_miss = 1'b1;
        #1 chk("rst_stall_follows_miss", 64'(stall), 64'd1);
        dc_miss = 1'b0;
        step();
        rst = 1'b0;
        step();

        serve(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_1234, 32'h0, 1);
        serve(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0100, 32'h0000_8040, 1);
        serve(1'b1, 1'b1, 1'b0, 32'h0000_2008, 32'h0000_4010, 32'h0, 1);
        serve(1'b1, 1'b1, 1'b1, 32'h0000_A000, 32'h0000_B01C, 32'h0000_C030, 1);
        serve(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_3330, 32'h0, 3);
        serve(1'b1, 1'b0, 1'b0, 32'h0000_7774, 32'h0, 32'h0, 3);

        for (int i = 0; i < 20; i++) begin
            mem_ready = ~mem_ready;
            step();
        end

        ic0 = ic_seen;
        cyc = 0;
        for (int i = 0; i < LW; i++)
            exp_q.push_back('{we: 1'b0, ic: 1'b1, addr: 32'h0000_5550 + 32'(4 * i), idx: i});
        ic_addr = 32'h0000_5558;
        ic_miss = 1'b1;
        mem_ready = 1'b1;
        while (ic_seen - ic0 < 2 && cyc < 50) begin step(); cyc++; end
        chk("midrst_reached_word1", 64'(ic_seen - ic0), 64'd2);
        rst = 1'b1; ic_miss = 1'b0; mem_ready = 1'b0;
        step();
        chk("midrst_mem_req", 64'(mem_req), 64'd0);
        chk("midrst_word_idx", 64'(word_idx), 64'd0);
        chk("midrst_stall", 64'(stall), 64'd0);
        chk("midrst_ic_fill", 64'(ic_fill), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            step();
        end
        serve(1'b1, 1'b0, 1'b0, 32'h0000_5558, 32'h0, 32'h0, 1);

        for (int i = 0; i < 25; i++) begin
            bit ic = 1'($urandom_range(0, 1));
            bit dc = 1'($urandom_range(0, 1));
            if (!ic && !dc) dc = 1'b1;
            serve(ic, dc, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                  $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
